// File: rtl/elastic_skid_buffer.sv
// Generic 2-entry valid/ready register slice. The main slot drives the output and the skid slot
// catches the token accepted in the cycle that the consumer stalls.
module elastic_skid_buffer #(
   parameter int DATA_TYPE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] ins,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   output logic [DATA_TYPE-1:0] outs,
   output logic                 outs_valid,
   input  logic                 outs_ready
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]           state;
   logic [DATA_TYPE-1:0] main_q;
   logic [DATA_TYPE-1:0] skid_q;
   logic                 push;
   logic                 pop;

   // Input readiness comes from registered state alone, so outs_ready never reaches ins_ready.
   assign ins_ready  = (state != FULL) & ~rst;
   assign push       = ins_valid & ins_ready;
   assign outs_valid = (state != EMPTY);
   assign pop        = outs_valid & outs_ready;
   assign outs       = main_q;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         // NOTE: the data slots are reset as well because dataOut must read zero after reset.
         main_q <= '0;
         skid_q <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  main_q <= ins;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_q <= ins;
               end else if (push) begin
                  skid_q <= ins;
                  state  <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_q <= skid_q;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/cond_mux_skid.sv
// Select-merge: the condition token chooses which input is consumed and forwarded, rejoining
// two paths that a branch split. The output is decoupled through a 2-entry skid buffer.
module cond_mux_skid #(
   parameter int DATA_TYPE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 condition,
   input  logic                 condition_valid,
   output logic                 condition_ready,
   input  logic [DATA_TYPE-1:0] trueIn,
   input  logic                 trueIn_valid,
   output logic                 trueIn_ready,
   input  logic [DATA_TYPE-1:0] falseIn,
   input  logic                 falseIn_valid,
   output logic                 falseIn_ready,
   output logic [DATA_TYPE-1:0] dataOut,
   output logic                 dataOut_valid,
   input  logic                 dataOut_ready
);

   logic                 sel_valid;
   logic [DATA_TYPE-1:0] sel_data;
   logic                 accept;
   logic                 fire;

   assign sel_valid = condition ? trueIn_valid : falseIn_valid;
   assign sel_data  = condition ? trueIn : falseIn;
   assign fire      = condition_valid & sel_valid & accept;

   // The non-selected input never sees ready, so its token stays in place.
   assign condition_ready = fire;
   assign trueIn_ready    = fire & condition;
   assign falseIn_ready   = fire & ~condition;

   elastic_skid_buffer #(
      .DATA_TYPE(DATA_TYPE)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .ins       (sel_data),
      .ins_valid (condition_valid & sel_valid),
      .ins_ready (accept),
      .outs      (dataOut),
      .outs_valid(dataOut_valid),
      .outs_ready(dataOut_ready)
   );

endmodule

// File: tb/tb_cond_mux_skid.sv
// Bench for cond_mux_skid: a directed vector table, hand-written multi-cycle sequences, and a
// random run against a queue model of a capacity-2 in-order channel.
module tb_cond_mux_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        condition, condition_valid, condition_ready;
   logic [31:0] trueIn, falseIn, dataOut;
   logic        trueIn_valid, trueIn_ready, falseIn_valid, falseIn_ready;
   logic        dataOut_valid, dataOut_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: tokens accepted but not yet taken, oldest first. At most two fit.
   logic [31:0] mq[$];
   logic        m_fire;
   logic        m_take;
   logic [31:0] m_data;

   always #5 clk = ~clk;

   cond_mux_skid #(.DATA_TYPE(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .condition      (condition),
      .condition_valid(condition_valid),
      .condition_ready(condition_ready),
      .trueIn         (trueIn),
      .trueIn_valid   (trueIn_valid),
      .trueIn_ready   (trueIn_ready),
      .falseIn        (falseIn),
      .falseIn_valid  (falseIn_valid),
      .falseIn_ready  (falseIn_ready),
      .dataOut        (dataOut),
      .dataOut_valid  (dataOut_valid),
      .dataOut_ready  (dataOut_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic cv, input logic tv, input logic [31:0] td,
                        input logic fv, input logic [31:0] fd, input logic ordy);
      condition       = c;
      condition_valid = cv;
      trueIn_valid    = tv;
      trueIn          = td;
      falseIn_valid   = fv;
      falseIn         = fd;
      dataOut_ready   = ordy;
   endtask

   // Mid-cycle: predict this cycle's handshakes from the model and compare.
   task automatic cycle_pre();
      #4;
      m_fire = !rst && condition_valid && (condition ? trueIn_valid : falseIn_valid)
               && (mq.size() < 2);
      m_data = condition ? trueIn : falseIn;
      m_take = (mq.size() > 0) && dataOut_ready;
      check("condition_ready", condition_ready, m_fire);
      check("trueIn_ready", trueIn_ready, m_fire && condition);
      check("falseIn_ready", falseIn_ready, m_fire && !condition);
      check("dataOut_valid", dataOut_valid, mq.size() > 0);
      if (mq.size() > 0) check("dataOut", dataOut, mq[0]);
   endtask

   task automatic cycle_post();
      @(posedge clk);
      if (rst) mq.delete();
      else begin
         if (m_take) void'(mq.pop_front());
         if (m_fire) mq.push_back(m_data);
      end
      #1;
   endtask

   task automatic cycle();
      cycle_pre();
      cycle_post();
   endtask

   typedef struct {
      logic        c, cv, tv;
      logic [31:0] td;
      logic        fv;
      logic [31:0] fd;
      logic        ordy;
      logic        cr, tr, fr, ov;
      logic [31:0] out;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [31:0] k;
      int          n_acc;
      logic        c_tok;
      logic [31:0] t_seq, f_seq;

      // Reset value zero, tokens 1 then 101, 2, 102 alternate, then an idle drain.
      tbl[0] = '{1'b1, 1'b1, 1'b1, 32'hA5, 1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 32'd1,  1'b1, 32'd101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 32'd2,  1'b1, 32'd101, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd1};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd2,  1'b1, 32'd102, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd101};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 32'd3,  1'b1, 32'd102, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 32'd3,  1'b0, 32'd103, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd102};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 32'd3,  1'b0, 32'd103, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset dataOut_valid", dataOut_valid, 1'b0);
      check("reset dataOut", dataOut, 32'd0);

      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].c, tbl[i].cv, tbl[i].tv, tbl[i].td, tbl[i].fv, tbl[i].fd, tbl[i].ordy);
         cycle_pre();
         check($sformatf("vec%0d condition_ready", i), condition_ready, tbl[i].cr);
         check($sformatf("vec%0d trueIn_ready", i), trueIn_ready, tbl[i].tr);
         check($sformatf("vec%0d falseIn_ready", i), falseIn_ready, tbl[i].fr);
         check($sformatf("vec%0d dataOut_valid", i), dataOut_valid, tbl[i].ov);
         if (tbl[i].ov) check($sformatf("vec%0d dataOut", i), dataOut, tbl[i].out);
         cycle_post();
      end

      // Condition waits for falseIn while trueIn is offered and must be left alone.
      drive(1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0, 1'b1);
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         cycle_pre();
         n_acc += int'(condition_ready) + int'(trueIn_ready) + int'(falseIn_ready);
         cycle_post();
      end
      check("held token readies", n_acc, 0);
      drive(1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 32'h22, 1'b1);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cycle_pre();
      check("held token delivered", dataOut, 32'h22);
      cycle_post();

      // Output stall: exactly two tokens accepted, then drain in order and resume.
      k = 32'h300;
      n_acc = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b1, 1'b1, k, 1'b0, 32'h0, i >= 6);
         cycle_pre();
         if (i < 6) n_acc += int'(condition_ready);
         cycle_post();
         if (m_fire) k++;
      end
      check("stall accepted count", n_acc, 2);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      repeat (3) cycle();

      // Reset while full drops both tokens; the next token goes through normally.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 32'h400 + i, 1'b0, 32'h0, 1'b0);
         cycle();
      end
      check("full before reset", dataOut_valid, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("post-reset dataOut_valid", dataOut_valid, 1'b0);
      check("post-reset dataOut", dataOut, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h55, 1'b0, 32'h0, 1'b1);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cycle_pre();
      check("post-reset token", dataOut, 32'h55);
      cycle_post();
      cycle();

      // Random traffic: each source is a numbered stream, tagged so mixing shows up.
      c_tok = 1'b1;
      t_seq = 0;
      f_seq = 0;
      for (int i = 0; i < 10000; i++) begin
         drive(c_tok, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               32'h1000_0000 | t_seq, $urandom_range(0, 2) != 0, 32'h2000_0000 | f_seq,
               $urandom_range(0, 3) != 0);
         cycle();
         if (m_fire) begin
            if (c_tok) t_seq++;
            else f_seq++;
            c_tok = logic'($urandom_range(0, 1));
         end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      repeat (3) cycle();
      check("random drained", dataOut_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
